// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared types and constants for the instruction fetch controller.
// The HALT state is only present when IF_HALT_DETECT_EN is defined.
package if_fetch_pkg;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] HALT_INSTR = 32'hEAFFFFFF;
  localparam int CNT_W = 16;
`ifdef IF_HALT_DETECT_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/if_fetch_ctrl_if.sv
// if_fetch_ctrl_if: fetch controller bus; master is the controller, slave the environment.
interface if_fetch_ctrl_if;
  import if_fetch_pkg::*;
  logic             freeze;
  logic             branch_taken;
  logic [31:0]      branch_addr;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_instr;
  logic [31:0]      if_instr;
  logic [31:0]      if_pc;
  logic             if_valid;
  logic             id_ready;
  logic [CNT_W-1:0] fetch_cnt;
  logic             halted;
  modport master (
    input  freeze, branch_taken, branch_addr, imem_instr, id_ready,
    output imem_addr, if_instr, if_pc, if_valid, fetch_cnt, halted
  );
  modport slave (
    output freeze, branch_taken, branch_addr, imem_instr, id_ready,
    input  imem_addr, if_instr, if_pc, if_valid, fetch_cnt, halted
  );
endinterface

// File: rtl/if_out_reg.sv
// if_out_reg: IF/ID output register; flush beats load, load beats drop (valid clear on acceptance).
module if_out_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic        drop,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);
  logic [31:0] instr_q, instr_d, pc_q, pc_d;
  logic        valid_q, valid_d;
  always_comb begin
    instr_d = flush ? '0 : load ? instr_i : instr_q;
    pc_d    = flush ? '0 : load ? pc_i : pc_q;
    valid_d = flush ? 1'b0 : load ? 1'b1 : drop ? 1'b0 : valid_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IDLE/RUN(/HALT) fetch FSM with PC, saturating capture counter and IF/ID register.
// Optional halt-on-self-branch detection is enabled by defining IF_HALT_DETECT_EN.
module if_fetch_ctrl
  import if_fetch_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  if_fetch_ctrl_if.master bus
);
  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d, pc_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run, redirect, capture, drop;
  logic             unused_ba;
  assign run      = state_q == S_RUN;
  assign redirect = run && bus.branch_taken;
  assign capture  = run && !bus.branch_taken && !bus.freeze && (!bus.if_valid || bus.id_ready);
  assign pc_inc   = pc_q + 32'd4;
  assign unused_ba = ^bus.branch_addr[1:0];
`ifdef IF_HALT_DETECT_EN
  logic halted_q, halted_d;
  assign drop       = state_q == S_HALT && bus.if_valid && bus.id_ready;
  assign bus.halted = halted_q;
`else
  assign drop       = 1'b0;
  assign bus.halted = 1'b0;
`endif
  always_comb begin
    state_d = state_q == S_IDLE ? S_RUN : state_q;
`ifdef IF_HALT_DETECT_EN
    if (capture && bus.imem_instr == HALT_INSTR) state_d = S_HALT;
    halted_d = state_d == S_HALT;
`endif
    pc_d  = redirect ? {bus.branch_addr[31:2], 2'b00} : capture ? pc_inc : pc_q;
    cnt_d = capture ? sat_inc(cnt_q) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
`ifdef IF_HALT_DETECT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
`ifdef IF_HALT_DETECT_EN
      halted_q <= halted_d;
`endif
    end
  end
  // imem_addr is forced to 0 combinationally while reset is asserted
  assign bus.imem_addr = (!rst_n || state_q == S_IDLE) ? '0 : {2'b00, pc_q[31:2]};
  assign bus.fetch_cnt = cnt_q;
  if_out_reg u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (capture),
    .flush   (redirect),
    .drop    (drop),
    .instr_i (bus.imem_instr),
    .pc_i    (pc_inc),
    .instr_o (bus.if_instr),
    .pc_o    (bus.if_pc),
    .valid_o (bus.if_valid)
  );
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed stimulus, per-cycle comparison against a behavioural fetch model
// plus literal spot checks. Halt expectations follow IF_HALT_DETECT_EN.
module tb_if_fetch_ctrl;
`ifdef IF_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halt_plant = 1'b0;
  logic done = 1'b0;
  int   checks = 0;
  int   failures = 0;
  if_fetch_ctrl_if bus();
  if_fetch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.imem_instr = (halt_plant && bus.imem_addr == 32'd46) ? 32'hEAFFFFFF : {8'h13, bus.imem_addr[23:0]};
  function automatic logic [31:0] mem_word(input logic [31:0] idx, input logic plant);
    return (plant && idx == 32'd46) ? 32'hEAFFFFFF : {8'h13, idx[23:0]};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask
  // model: phase 0=idle 1=run 2=halt
  int          m_phase = 0;
  logic [31:0] m_pc = 0, m_instr = 0, m_ifpc = 0;
  logic        m_valid = 0;
  int          m_cnt = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_pc = 0; m_instr = 0; m_ifpc = 0; m_valid = 0; m_cnt = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (bus.branch_taken) begin
        m_pc = bus.branch_addr & 32'hFFFF_FFFC; m_valid = 0; m_instr = 0; m_ifpc = 0;
      end else if (!bus.freeze && (!m_valid || bus.id_ready)) begin
        m_instr = mem_word(m_pc / 4, halt_plant);
        m_pc = m_pc + 4;
        m_ifpc = m_pc;
        m_valid = 1;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (HALT_EN && m_instr == 32'hEAFFFFFF) m_phase = 2;
      end
    end else if (m_valid && bus.id_ready) begin
      m_valid = 0;
    end
  end
  always @(negedge clk) begin
    if (!done) begin
      chk("imem_addr", bus.imem_addr, (!rst_n || m_phase == 0) ? 32'd0 : m_pc / 4);
      chk("if_valid", {31'd0, bus.if_valid}, {31'd0, m_valid});
      chk("if_instr", bus.if_instr, m_instr);
      chk("if_pc", bus.if_pc, m_ifpc);
      chk("fetch_cnt", {16'd0, bus.fetch_cnt}, m_cnt);
      chk("halted", {31'd0, bus.halted}, {31'd0, m_phase == 2});
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  initial begin
    bus.freeze = 0; bus.branch_taken = 0; bus.branch_addr = 0; bus.id_ready = 1;
    step(2);
    chk("rst_valid", {31'd0, bus.if_valid}, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_cnt", {16'd0, bus.fetch_cnt}, 0);
    rst_n = 1; bus.branch_taken = 1; bus.branch_addr = 32'h80;
    step();
    chk("idle_br_ignored", bus.imem_addr, 0);
    chk("idle_no_capture", {31'd0, bus.if_valid}, 0);
    bus.branch_taken = 0;
    step();
    chk("run1_pc", bus.if_pc, 32'd4);
    chk("run1_instr", bus.if_instr, 32'h13000000);
    chk("run1_addr", bus.imem_addr, 32'd1);
    step();
    chk("run2_pc", bus.if_pc, 32'd8);
    chk("run2_addr", bus.imem_addr, 32'd2);
    step();
    chk("run3_pc", bus.if_pc, 32'd12);
    chk("run3_cnt", {16'd0, bus.fetch_cnt}, 32'd3);
    step();
    chk("pc10_addr", bus.imem_addr, 32'd4);
    bus.freeze = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_addr", bus.imem_addr, 32'd4);
      chk("frz_pc", bus.if_pc, 32'h10);
      chk("frz_cnt", {16'd0, bus.fetch_cnt}, 32'd4);
    end
    bus.freeze = 0;
    step();
    chk("resume_pc", bus.if_pc, 32'h14);
    chk("resume_addr", bus.imem_addr, 32'd5);
    bus.freeze = 1; bus.branch_taken = 1; bus.branch_addr = 32'h43;
    step();
    chk("br_valid", {31'd0, bus.if_valid}, 0);
    chk("br_addr", bus.imem_addr, 32'h10);
    chk("br_cnt", {16'd0, bus.fetch_cnt}, 32'd5);
    bus.freeze = 0; bus.branch_taken = 0;
    step();
    chk("br_tgt_pc", bus.if_pc, 32'h44);
    chk("br_tgt_instr", bus.if_instr, 32'h13000010);
    bus.id_ready = 0;
    step(2);
    chk("stall_pc", bus.if_pc, 32'h44);
    chk("stall_addr", bus.imem_addr, 32'h11);
    bus.id_ready = 1;
    step();
    chk("release_pc", bus.if_pc, 32'h48);
    step();
    chk("release2_pc", bus.if_pc, 32'h4C);
    bus.id_ready = 0; bus.branch_taken = 1; bus.branch_addr = 32'hFFFFFFFE;
    step();
    chk("wrap_addr", bus.imem_addr, 32'h3FFFFFFF);
    chk("wrap_flush", {31'd0, bus.if_valid}, 0);
    bus.id_ready = 1; bus.branch_taken = 0;
    step();
    chk("wrap_pc", bus.if_pc, 32'd0);
    chk("wrap_instr", bus.if_instr, 32'h13FFFFFF);
    halt_plant = 1; bus.branch_taken = 1; bus.branch_addr = 32'hB8;
    step();
    bus.branch_taken = 0;
    step();
    chk("halt_instr", bus.if_instr, 32'hEAFFFFFF);
    chk("halt_addr", bus.imem_addr, 32'h2F);
    chk("halt_flag", {31'd0, bus.halted}, {31'd0, HALT_EN});
    bus.id_ready = 0; bus.branch_taken = 1; bus.branch_addr = 32'h100; bus.freeze = 1;
    step(2);
    chk("halt_br_addr", bus.imem_addr, HALT_EN ? 32'h2F : 32'h40);
    bus.id_ready = 1; bus.branch_taken = 0; bus.freeze = 0;
    step();
    if (HALT_EN) begin
      chk("halt_consumed", {31'd0, bus.if_valid}, 0);
      chk("halt_pc_frozen", bus.imem_addr, 32'h2F);
    end
    rst_n = 0;
    step();
    chk("halt_rst_flag", {31'd0, bus.halted}, 0);
    chk("halt_rst_addr", bus.imem_addr, 0);
    rst_n = 1; halt_plant = 0;
    step();
    step(65534);
    chk("cnt_fffe", {16'd0, bus.fetch_cnt}, 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("cnt_sat", {16'd0, bus.fetch_cnt}, 32'hFFFF);
    end
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
- REQ-001: The block SHALL use one clock; reset SHALL be synchronous and active-low.
- REQ-002: clk  input  1  system clock; all state SHALL update on its rising edge.
- REQ-003: rst_n  input  1  synchronous active-low reset.
- REQ-004: freeze  input  1  hazard stall from the hazard unit; when high, the fetch SHALL hold.
- REQ-005: branch_taken  input  1  branch resolved taken; SHALL redirect the PC and flush the fetch.
- REQ-006: branch_addr  input  32  byte address of the branch target.
- REQ-007: imem_addr  output  32  word index to the combinational instruction memory, equal to pc[31:2] zero-extended.
- REQ-008: imem_instr  input  32  instruction returned combinationally for imem_addr.
- REQ-009: if_instr  output  32  registered instruction presented to the IF/ID stage.
- REQ-010: if_pc  output  32  registered PC+4 of if_instr.
- REQ-011: if_valid  output  1  high when if_instr/if_pc are valid.
- REQ-012: id_ready  input  1  consumer accepts the output when if_valid && id_ready.
- REQ-013: fetch_cnt  output  16  count of captured instructions, saturating.
- REQ-014: halted  output  1  high in HALT state.

Function
- REQ-015: The FSM SHALL have states IDLE, RUN and HALT; HALT SHALL exist only when the macro is defined.
- REQ-016: IDLE SHALL last exactly one cycle after rst_n deasserts, then go to RUN; no capture SHALL occur in IDLE.
- REQ-017: In RUN, advance = !freeze && (!if_valid || id_ready).
- REQ-018: On advance without branch_taken: if_instr <= imem_instr, if_pc <= pc+4, if_valid <= 1, pc <= pc+4, and fetch_cnt SHALL increment.
- REQ-019: In RUN with !advance and !branch_taken, pc, if_instr, if_pc and if_valid SHALL hold.
- REQ-020: branch_taken SHALL have priority over freeze and id_ready: pc <= branch_addr, if_valid <= 0, if_instr <= 0, if_pc <= 0, and no count increment; the bubble lasts exactly one cycle.
- REQ-021: Capture-to-output latency SHALL be one cycle, giving a throughput of one instruction per cycle when id_ready=1 and freeze=0.
- REQ-022: The pc SHALL wrap modulo 2^32; branch_addr[1:0] SHALL be ignored, and pc[1:0] SHALL always be 0.
- REQ-023: fetch_cnt SHALL saturate at 0xFFFF and never wrap.
- REQ-024: branch_taken in IDLE SHALL be ignored.

Reset
- REQ-025: When rst_n=0 at a clock edge, the block SHALL set state=IDLE, pc=0, if_instr=0, if_pc=0, if_valid=0, fetch_cnt=0 and halted=0, regardless of any operation in progress, including HALT or a pending branch.
- REQ-026: imem_addr SHALL read 0 during reset and in IDLE.

Configuration
- REQ-027: Macro IF_HALT_DETECT_EN: when defined, capturing the word 32'hEAFFFFFF (B #-1) SHALL load it normally and move RUN->HALT.
- REQ-028: In HALT, the captured word SHALL remain until consumed (if_valid clears on acceptance), pc SHALL freeze, branch_taken and freeze SHALL be ignored, halted=1, and the state SHALL exit only via reset.
- REQ-029: Without IF_HALT_DETECT_EN, there SHALL be no HALT state, halted SHALL be tied to 0, and 32'hEAFFFFFF SHALL be fetched like any other word.

Structure
- REQ-030: Package if_fetch_pkg SHALL hold the FSM state enum, RESET_PC (32'h0), HALT_INSTR (32'hEAFFFFFF) and CNT_W (16).
- REQ-031: One sub-module, if_out_reg, SHALL implement the valid/ready output register with its flush input; the FSM, PC and counter SHALL stay in the top.

Verification
- REQ-032: Reset, then free run with id_ready=1, freeze=0 -> imem_addr 0,1,2,3 on consecutive RUN cycles, and if_pc 4,8,12 with if_valid=1 from the second RUN cycle.
- REQ-033: Hold freeze=1 for 3 cycles at pc=0x10 -> imem_addr=4, outputs and fetch_cnt stable for 3 cycles; resume from pc=0x14.
- REQ-034: branch_taken=1 with branch_addr=0x40 while freeze=1 -> next cycle if_valid=0 and imem_addr=0x10; following cycle if_pc=0x44.
- REQ-035: Hold id_ready=0 with if_valid=1 -> if_instr held, pc not advanced; release id_ready -> exactly one acceptance per cycle with no duplicated or lost instruction.
- REQ-036: With the macro defined, place 32'hEAFFFFFF at index 46 -> halted=1 after capture, pc=0xBC frozen, and branch_taken=1 ignored; pulse rst_n=0 -> pc=0 and halted=0.
- REQ-037: Force fetch_cnt to 0xFFFE, then run 3 captures -> fetch_cnt=0xFFFF and held.
